// File: rtl/window_load_controller.sv
// Sequencing FSM for the convolution front end's window address generator:
// per window it issues four line reads, drains the memory latency, starts the PE and waits.
module window_load_controller #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       line_last,
    input  logic       window_last,
    input  logic       pe_done,
    output logic       en_line_cntr,
    output logic       en_window_startpos_cntr,
    output logic       mem_rd,
    output logic       buf_wr,
    output logic [1:0] buf_wr_idx,
    output logic       compute_start,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        CSTART,
        WAIT_PE,
        ADVANCE,
        FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                line_idx_q, line_idx_d;
    logic [2:0]                drain_cnt_q, drain_cnt_d;
    logic                      en_line_cntr_q, en_line_cntr_d;
    logic                      en_win_q, en_win_d;
    logic                      mem_rd_q, mem_rd_d;
    logic                      compute_start_q, compute_start_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [MEM_LAT-1:0]        wr_vld_q, wr_vld_d;
    logic [MEM_LAT-1:0][1:0]   wr_idx_q, wr_idx_d;

    always_comb begin
        state_d     = state_q;
        line_idx_d  = '0;
        drain_cnt_d = '0;
        unique case (state_q)
            IDLE:    if (start) state_d = READ;
            READ: begin
                line_idx_d = line_idx_q + 2'd1;
                if (line_last) state_d = DRAIN;
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 3'd1;
                if (drain_cnt_q == 3'(MEM_LAT - 1)) state_d = CSTART;
            end
            CSTART:  state_d = WAIT_PE;
            WAIT_PE: if (pe_done) state_d = ADVANCE;
            ADVANCE: state_d = window_last ? FIN : READ;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with the state.
        en_line_cntr_d  = (state_d == READ);
        mem_rd_d        = (state_d == READ);
        en_win_d        = (state_d == ADVANCE);
        compute_start_d = (state_d == CSTART);
        done_d          = (state_d == FIN);
        busy_d          = (state_d != IDLE);

        wr_vld_d[0] = mem_rd_q;
        wr_idx_d[0] = line_idx_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            wr_vld_d[i] = wr_vld_q[i-1];
            wr_idx_d[i] = wr_idx_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            line_idx_q      <= '0;
            drain_cnt_q     <= '0;
            en_line_cntr_q  <= 1'b0;
            en_win_q        <= 1'b0;
            mem_rd_q        <= 1'b0;
            compute_start_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            wr_vld_q        <= '0;
            wr_idx_q        <= '0;
        end else begin
            state_q         <= state_d;
            line_idx_q      <= line_idx_d;
            drain_cnt_q     <= drain_cnt_d;
            en_line_cntr_q  <= en_line_cntr_d;
            en_win_q        <= en_win_d;
            mem_rd_q        <= mem_rd_d;
            compute_start_q <= compute_start_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            wr_vld_q        <= wr_vld_d;
            wr_idx_q        <= wr_idx_d;
        end
    end

    assign en_line_cntr            = en_line_cntr_q;
    assign en_window_startpos_cntr = en_win_q;
    assign mem_rd                  = mem_rd_q;
    assign compute_start           = compute_start_q;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign buf_wr                  = wr_vld_q[MEM_LAT-1];
    assign buf_wr_idx              = wr_idx_q[MEM_LAT-1];

endmodule

// File: tb/tb_window_load_controller.sv
// Bench for window_load_controller: scoreboarded full frames at MEM_LAT=1 and a
// cycle-exact first-window trace at MEM_LAT=3, with address generator and PE models.
`timescale 1ns/1ps
module tb_window_load_controller;

    localparam int LAT_A     = 1;
    localparam int LAT_B     = 3;
    localparam int PE_DLY    = 2;
    localparam int WIN_CYC   = 4 + LAT_A + 1 + PE_DLY + 1;
    localparam int FRAME_CYC = 100 * WIN_CYC + 1;
    localparam int BUDGET    = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_a, line_last_a, window_last_a, pe_done_a;
    logic       en_line_a, en_win_a, mem_rd_a, buf_wr_a, cs_a, busy_a, done_a;
    logic [1:0] buf_wr_idx_a;
    logic       start_b, line_last_b;
    logic       en_line_b, en_win_b, mem_rd_b, buf_wr_b, cs_b, busy_b, done_b;
    logic [1:0] buf_wr_idx_b;
    logic       pe_auto, pe_extra;

    window_load_controller #(.MEM_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .line_last(line_last_a),
        .window_last(window_last_a), .pe_done(pe_done_a),
        .en_line_cntr(en_line_a), .en_window_startpos_cntr(en_win_a),
        .mem_rd(mem_rd_a), .buf_wr(buf_wr_a), .buf_wr_idx(buf_wr_idx_a),
        .compute_start(cs_a), .busy(busy_a), .done(done_a)
    );

    window_load_controller #(.MEM_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .line_last(line_last_b),
        .window_last(1'b0), .pe_done(1'b0),
        .en_line_cntr(en_line_b), .en_window_startpos_cntr(en_win_b),
        .mem_rd(mem_rd_b), .buf_wr(buf_wr_b), .buf_wr_idx(buf_wr_idx_b),
        .compute_start(cs_b), .busy(busy_b), .done(done_b)
    );

    // Address generator model: line counter 0..3, window position 10x10.
    logic [1:0] line_a, line_b;
    logic [3:0] wi, wj;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_a <= '0; line_b <= '0; wi <= '0; wj <= '0;
        end else begin
            if (en_line_a) line_a <= line_a + 2'd1;
            if (en_line_b) line_b <= line_b + 2'd1;
            if (en_win_a) begin
                if (wj == 4'd9) begin
                    wj <= '0;
                    wi <= (wi == 4'd9) ? 4'd0 : wi + 4'd1;
                end else begin
                    wj <= wj + 4'd1;
                end
            end
        end
    end
    assign line_last_a   = (line_a == 2'd3);
    assign line_last_b   = (line_b == 2'd3);
    assign window_last_a = (wi == 4'd9) && (wj == 4'd9);
    assign pe_done_a     = pe_auto | pe_extra;

    typedef struct { int cyc; logic [1:0] idx; } wr_t;
    wr_t wr_q[$];

    int n_cmp = 0, n_err = 0, cyc = 0;
    int n_rd = 0, n_wr = 0, n_cs = 0, n_enw = 0, n_done = 0;
    int b_rd, b_wr, b_cs, b_enw, b_done, f_start;
    int last_cs = -1, pe_cnt = 0;
    bit pe_auto_en = 1'b1, period_chk = 1'b0, prev_enw = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs_a();
        return {en_line_a, en_win_a, mem_rd_a, buf_wr_a,
                buf_wr_a ? buf_wr_idx_a : 2'd0, cs_a, busy_a, done_a};
    endfunction

    function automatic logic [8:0] outs_b();
        return {en_line_b, en_win_b, mem_rd_b, buf_wr_b,
                buf_wr_b ? buf_wr_idx_b : 2'd0, cs_b, busy_b, done_b};
    endfunction

    // Per-cycle monitor for dut_a; also plays the PE, answering PE_DLY cycles after compute_start.
    task automatic mon();
        wr_t e;
        cyc++;
        pe_auto = 1'b0;
        if (!rst) begin
            wr_q.delete();
            last_cs  = -1;
            pe_cnt   = 0;
            prev_enw = 1'b0;
        end else begin
            if (pe_cnt > 0) begin
                pe_cnt--;
                if (pe_cnt == 0) pe_auto = 1'b1;
            end
            if (buf_wr_a) begin
                n_wr++;
                chk("wr_expected", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    e = wr_q.pop_front();
                    chk("wr_latency", cyc - e.cyc, LAT_A);
                    chk("wr_idx", buf_wr_idx_a, e.idx);
                end
            end
            if (mem_rd_a) begin
                e.cyc = cyc;
                e.idx = line_a;
                wr_q.push_back(e);
                n_rd++;
            end
            if (cs_a) begin
                n_cs++;
                chk("cs_writes_landed", wr_q.size(), 0);
                if (period_chk && last_cs >= 0) chk("win_period", cyc - last_cs, WIN_CYC);
                last_cs = cyc;
                if (pe_auto_en) pe_cnt = PE_DLY;
            end
            if (en_win_a) n_enw++;
            if (done_a) begin
                n_done++;
                chk("done_after_adv", prev_enw, 1);
                last_cs = -1;
            end
            prev_enw = en_win_a;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic start_frame(input string tag);
        b_rd = n_rd; b_wr = n_wr; b_cs = n_cs; b_enw = n_enw; b_done = n_done;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        f_start = cyc - 1;
        chk($sformatf("%s_busy_rise", tag), busy_a, 1);
    endtask

    task automatic finish_frame(input string tag, input bit check_len);
        bit hit = 1'b0;
        for (int k = 0; k < BUDGET && !hit; k++) begin
            tick();
            hit = done_a;
        end
        chk($sformatf("%s_done_seen", tag), hit, 1);
        if (check_len) chk($sformatf("%s_frame_len", tag), cyc - f_start, FRAME_CYC);
        tick();
        chk($sformatf("%s_busy_fall", tag), busy_a, 0);
        chk($sformatf("%s_n_cs", tag), n_cs - b_cs, 100);
        chk($sformatf("%s_n_rd", tag), n_rd - b_rd, 400);
        chk($sformatf("%s_n_wr", tag), n_wr - b_wr, 400);
        chk($sformatf("%s_n_enw", tag), n_enw - b_enw, 100);
        chk($sformatf("%s_n_done", tag), n_done - b_done, 1);
        chk($sformatf("%s_end_pos", tag), {wi, wj, line_a}, 0);
        chk($sformatf("%s_wrq_empty", tag), wr_q.size(), 0);
    endtask

    initial begin
        bit         hit, w;
        int         viol;
        logic [8:0] expv;
        logic [8:0] exp_b[$];

        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; pe_extra = 1'b0; pe_auto = 1'b0;
        tick(); tick();
        chk("rst_outs_a", outs_a(), 0);
        chk("rst_idx_a", buf_wr_idx_a, 0);
        chk("rst_outs_b", outs_b(), 0);
        rst = 1'b1;
        tick(); tick();
        chk("idle_outs_a", outs_a(), 0);

        // MEM_LAT=3 first window, expected per cycle 1..12 queued as the start is driven
        for (int c = 1; c <= 12; c++) begin
            w = (c >= 4) && (c <= 7);
            expv = {(c <= 4), 1'b0, (c <= 4), w, w ? 2'(c - 4) : 2'd0, (c == 8), 1'b1, 1'b0};
            exp_b.push_back(expv);
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            chk($sformatf("l3_cyc%0d", c), outs_b(), exp_b.pop_front());
        end
        rst = 1'b0;
        tick();
        chk("l3_rst_outs", outs_b(), 0);
        tick();
        rst = 1'b1;
        tick();

        // Two clean frames, the second started the cycle after done
        period_chk = 1'b1;
        start_frame("f1");
        finish_frame("f1", 1'b1);
        start_frame("f2");
        finish_frame("f2", 1'b1);
        chk("b2b_cs_total", n_cs, 200);

        // PE stalls 51 cycles, then stray start/pe_done during READ
        period_chk = 1'b0;
        pe_auto_en = 1'b0;
        start_frame("f3");
        hit = 1'b0;
        for (int k = 0; k < BUDGET && !hit; k++) begin
            tick();
            hit = cs_a;
        end
        chk("f3_cs_seen", hit, 1);
        viol = 0;
        for (int k = 0; k < 51; k++) begin
            tick();
            if (outs_a() != 9'b0_0000_0010) viol++;
        end
        chk("f3_wait_hold", viol, 0);
        pe_extra = 1'b1;
        tick();
        pe_extra = 1'b0;
        chk("f3_enw_after_pe", en_win_a, 1);
        pe_auto_en = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < BUDGET && !hit; k++) begin
            tick();
            hit = mem_rd_a;
        end
        chk("f3_read_seen", hit, 1);
        start_a  = 1'b1;
        pe_extra = 1'b1;
        tick();
        start_a  = 1'b0;
        pe_extra = 1'b0;
        finish_frame("f3", 1'b0);

        // Asynchronous reset in window 37 during READ, then a full restart
        period_chk = 1'b1;
        start_frame("f4");
        hit = 1'b0;
        for (int k = 0; k < BUDGET && !hit; k++) begin
            tick();
            hit = (wi == 4'd3) && (wj == 4'd7) && mem_rd_a && (line_a == 2'd1);
        end
        chk("f4_w37_seen", hit, 1);
        rst = 1'b0;
        #1;
        chk("f4_async_outs", outs_a(), 0);
        chk("f4_async_idx", buf_wr_idx_a, 0);
        chk("f4_async_pos", {wi, wj, line_a}, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        start_frame("f5");
        finish_frame("f5", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
